i2c_master: RTL and testbench
=============================

# i2c_master

Byte-level I2C master controller that generates the SCL/SDA traffic consumed by `I2C_slave`. Accepts one command at a time (7-bit address, R/W, one data byte) over a valid/ready handshake. Emits START, address+R/W, ACK slot, one data byte (write) or receives one byte (read), ACK/NACK slot, STOP. Sits directly upstream of the slave; it is the bus driver for slave tests and the system-side bus master.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per quarter SCL bit period. Legal range 4..255.
- `clk  in  1`: sole clock, rising edge.
- `reset  in  1`: synchronous, active-low reset.
- `cmd_valid  in  1`: command present.
- `cmd_ready  out  1`: block can accept a command.
- `cmd_addr  in  7`: target address.
- `cmd_rw  in  1`: 0 = write, 1 = read.
- `cmd_wdata  in  8`: write byte; ignored on reads.
- `scl  out  1`: I2C clock, push-pull.
- `sda_oe  out  1`: 1 = pull SDA low; 0 = release (open-drain).
- `sda_in  in  1`: resolved SDA line.
- `busy  out  1`: transaction in progress.
- `done  out  1`: one-cycle completion pulse.
- `ack_err  out  1`: slave NACKed; valid while `done`=1, held until next accept.
- `rd_data  out  8`: read byte; valid while `done`=1, held until next accept.

## Operation
- Reset (`reset`=0 at a rising edge): state IDLE, `scl`=1, `sda_oe`=0, `cmd_ready`=1, `busy`=0, `done`=0, `ack_err`=0, `rd_data`=0, counters cleared. Mid-transaction reset abandons the bus immediately; no STOP is generated.
- Handshake: `cmd_ready`=1 only in IDLE. A command is accepted on a cycle with `cmd_valid && cmd_ready`. Address, R/W and data are latched on that cycle. `cmd_valid` outside IDLE is ignored.
- State sequence: IDLE -> START -> ADDR (8 bits: addr[6:0] MSB first, then rw) -> AACK.
- From AACK:
  - Write: -> WDATA (8 bits, MSB first) -> WACK -> STOP.
  - Read: -> RDATA (8 bits) -> RNACK -> STOP.
  - STOP -> IDLE.
- ACK slots (AACK, WACK): master releases SDA and samples it. Sample = 1 means NACK: set `ack_err`=1 and go directly to STOP, skipping remaining bits.
- RDATA: master releases SDA and shifts the sampled bits into `rd_data` MSB first.
- RNACK: master releases SDA, i.e. sends NACK for the single-byte read.
- `sda_in` passes through a 2-flop synchronizer before it is sampled.

## Timing
- Bit period = 4 quarters (q0..q3), each quarter `CLK_DIV` cycles.
- Data bits and ACK slots:
  - `scl`=0 in q0–q1, `scl`=1 in q2–q3.
  - `sda_oe` updates on the first cycle of q0.
  - SDA is sampled (synchronized value) on the first cycle of q3.
- START: `scl`=1 throughout; `sda_oe`=0 in q0–q1, `sda_oe`=1 in q2–q3 (SDA falls while SCL is high).
- STOP:
  - q0: `scl`=0, `sda_oe`=1.
  - q1: `scl`=1, `sda_oe`=1.
  - q2–q3: `scl`=1, `sda_oe`=0 (SDA rises while SCL is high).
- Full transaction = 20 bit periods = 80·`CLK_DIV` cycles after the accept cycle.
- Address-NACK transaction = 11 bit periods.
- `done` is asserted on the cycle after the last STOP cycle. On that same cycle the block is in IDLE with `cmd_ready`=1, so a back-to-back command is accepted on the `done` cycle and START begins on the next cycle.
- `busy`=1 from the cycle after accept through the last STOP cycle.

## Structure
- Package `i2c_pkg`:
  - State enum (IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RNACK, STOP).
  - Quarter-phase enum.
  - Constants `I2C_ADDR_W`=7, `I2C_DATA_W`=8.
- Sub-module `i2c_bit_timer`:
  - Quarter-tick counter (width `$clog2(CLK_DIV)`).
  - Outputs the current quarter and an end-of-bit strobe.
  - Cleared by reset and on accept.
- Main FSM uses a 3-bit bit counter that wraps 7 -> 0 at byte end.

## Test plan
- Write, `CLK_DIV`=4, addr 0x50, wdata 0xA5, slave ACKs both slots -> SDA bits 1010000_0 then 10100101. `done` 320 cycles after accept. `ack_err`=0. `I2C_slave` ADRESS_OUT=0x50, DATA_OUT=0xA5.
- Address NACK (no slave at 0x3F) -> `ack_err`=1, no data bits driven, STOP follows AACK, `done` 44·`CLK_DIV` cycles after accept.
- Read, addr 0x21, rw=1, bench drives 0x3C -> `rd_data`=0x3C at `done`. `sda_oe`=0 throughout RDATA and RNACK.
- Back-to-back: `cmd_valid` held high with two commands -> second accepted on the first `done` cycle. START of the second begins on the next cycle. `cmd_valid` during `busy` has no effect.
- Reset asserted mid-WDATA -> next cycle `scl`=1, `sda_oe`=0, `busy`=0, `cmd_ready`=1. A fresh command then completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and helpers for the byte-level I2C master.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_DATA_W = 8;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_ADDR,
      ST_AACK,
      ST_WDATA,
      ST_WACK,
      ST_RDATA,
      ST_RNACK,
      ST_STOP
   } i2c_state_e;

   typedef enum logic [1:0] {
      Q0,
      Q1,
      Q2,
      Q3
   } i2c_quarter_e;

   function automatic i2c_quarter_e next_quarter(input i2c_quarter_e q);
      return i2c_quarter_e'(q + 2'd1);
   endfunction

   // Bus levels {scl, sda_oe} for a given state, quarter and outgoing data bit.
   function automatic logic [1:0] bus_drive(input i2c_state_e st,
                                            input i2c_quarter_e q,
                                            input logic bit_v);
      logic scl_v;
      logic oe_v;
      scl_v = 1'b1;
      oe_v  = 1'b0;
      case (st)
         ST_START: oe_v = (q == Q2) || (q == Q3);
         ST_ADDR, ST_WDATA: begin
            scl_v = (q == Q2) || (q == Q3);
            oe_v  = ~bit_v;
         end
         ST_AACK, ST_WACK, ST_RDATA, ST_RNACK: scl_v = (q == Q2) || (q == Q3);
         ST_STOP: begin
            scl_v = (q != Q0);
            oe_v  = (q == Q0) || (q == Q1);
         end
         default: begin
            scl_v = 1'b1;
            oe_v  = 1'b0;
         end
      endcase
      return {scl_v, oe_v};
   endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-bit timer: divides clk into four quarters per SCL bit period.
module i2c_bit_timer
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear_i,
   input  logic         run_i,
   output i2c_quarter_e quarter_o,
   output logic         qstart_o,
   output logic         qend_o,
   output logic         bit_end_o
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   i2c_quarter_e  quarter_q;

   // Count clk cycles within a quarter and step the quarter at its end.
   always_ff @(posedge clk) begin
      if (!reset || clear_i) begin
         cnt_q     <= '0;
         quarter_q <= Q0;
      end else if (run_i) begin
         if (cnt_q == CNT_MAX) begin
            cnt_q     <= '0;
            quarter_q <= next_quarter(quarter_q);
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign quarter_o = quarter_q;
   assign qstart_o  = (cnt_q == '0);
   assign qend_o    = (cnt_q == CNT_MAX);
   assign bit_end_o = (cnt_q == CNT_MAX) && (quarter_q == Q3);

endmodule

// File: rtl/i2c_master.sv
// Single-command I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE and cmd_valid is ignored at all other times.
module i2c_master
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [I2C_ADDR_W-1:0] cmd_addr,
   input  logic                  cmd_rw,
   input  logic [I2C_DATA_W-1:0] cmd_wdata,
   output logic                  scl,
   output logic                  sda_oe,
   input  logic                  sda_in,
   output logic                  busy,
   output logic                  done,
   output logic                  ack_err,
   output logic [I2C_DATA_W-1:0] rd_data,
   output i2c_state_e            dbg_state
);

   i2c_state_e            state_q, state_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [I2C_DATA_W-1:0] sh_q, sh_d;
   logic [I2C_DATA_W-1:0] wdata_q;
   logic [I2C_DATA_W-1:0] rd_q;
   logic                  rw_q;
   logic                  ack_err_q;
   logic                  done_q;
   logic                  scl_q;
   logic                  sda_oe_q;
   logic                  sda_s1_q, sda_s2_q;

   logic                  accept;
   logic                  sample;
   i2c_quarter_e          quarter;
   i2c_quarter_e          q_nxt;
   logic                  qstart, qend, bit_end;
   logic [1:0]            drive_d;

   assign accept = cmd_valid && (state_q == ST_IDLE);

   i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (accept),
      .run_i     (state_q != ST_IDLE),
      .quarter_o (quarter),
      .qstart_o  (qstart),
      .qend_o    (qend),
      .bit_end_o (bit_end)
   );

   // SDA is sampled at the start of q3 in the slots where the slave owns the line.
   assign sample = qstart && (quarter == Q3) &&
                   ((state_q == ST_AACK) || (state_q == ST_WACK) || (state_q == ST_RDATA));

   // Next state, bit counter, shift register and the quarter seen next cycle.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      q_nxt     = quarter;
      if (accept) begin
         state_d   = ST_START;
         bit_cnt_d = 3'd0;
         sh_d      = {cmd_addr, cmd_rw};
         q_nxt     = Q0;
      end else if (state_q != ST_IDLE) begin
         if (qend) q_nxt = next_quarter(quarter);
         if (bit_end) begin
            case (state_q)
               ST_START: state_d = ST_ADDR;
               ST_ADDR: begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  sh_d      = {sh_q[I2C_DATA_W-2:0], 1'b0};
                  if (bit_cnt_q == 3'd7) state_d = ST_AACK;
               end
               ST_AACK: begin
                  if (ack_err_q) begin
                     state_d = ST_STOP;
                  end else if (rw_q) begin
                     state_d = ST_RDATA;
                  end else begin
                     state_d = ST_WDATA;
                     sh_d    = wdata_q;
                  end
               end
               ST_WDATA: begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  sh_d      = {sh_q[I2C_DATA_W-2:0], 1'b0};
                  if (bit_cnt_q == 3'd7) state_d = ST_WACK;
               end
               ST_WACK: state_d = ST_STOP;
               ST_RDATA: begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_d = ST_RNACK;
               end
               ST_RNACK: state_d = ST_STOP;
               ST_STOP:  state_d = ST_IDLE;
               default:  state_d = ST_IDLE;
            endcase
         end
      end
   end

   assign drive_d = bus_drive(state_d, q_nxt, sh_d[I2C_DATA_W-1]);

   // Main FSM with registered bus outputs and result capture.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 3'd0;
         sh_q      <= '0;
         wdata_q   <= '0;
         rw_q      <= 1'b0;
         rd_q      <= '0;
         ack_err_q <= 1'b0;
         done_q    <= 1'b0;
         scl_q     <= 1'b1;
         sda_oe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sh_q      <= sh_d;
         scl_q     <= drive_d[1];
         sda_oe_q  <= drive_d[0];
         done_q    <= (state_q == ST_STOP) && bit_end;
         if (accept) begin
            wdata_q   <= cmd_wdata;
            rw_q      <= cmd_rw;
            rd_q      <= '0;
            ack_err_q <= 1'b0;
         end else if (sample) begin
            if (state_q == ST_RDATA) rd_q <= {rd_q[I2C_DATA_W-2:0], sda_s2_q};
            else if (sda_s2_q)       ack_err_q <= 1'b1;
         end
      end
   end

   // Two-flop synchronizer for the resolved SDA line; idle bus reads high.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
      end else begin
         sda_s1_q <= sda_in;
         sda_s2_q <= sda_s1_q;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign ack_err   = ack_err_q;
   assign rd_data   = rd_q;
   assign scl       = scl_q;
   assign sda_oe    = sda_oe_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a small behavioural I2C slave on the bus.
module tb_i2c_master;
   import i2c_pkg::*;

   localparam int CLK_DIV = 4;
   localparam int FULL_CYC = 80 * CLK_DIV;
   localparam int NACK_CYC = 44 * CLK_DIV;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [6:0] cmd_addr = '0;
   logic       cmd_rw = 1'b0;
   logic [7:0] cmd_wdata = '0;
   logic       scl, sda_oe, sda_in;
   logic       busy, done, ack_err;
   logic [7:0] rd_data;
   i2c_state_e dbg_state;

   logic slave_low = 1'b0;
   assign sda_in = ~(sda_oe | slave_low);

   i2c_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_rw    (cmd_rw),
      .cmd_wdata (cmd_wdata),
      .scl       (scl),
      .sda_oe    (sda_oe),
      .sda_in    (sda_in),
      .busy      (busy),
      .done      (done),
      .ack_err   (ack_err),
      .rd_data   (rd_data),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_byte(input string tag, input logic [7:0] got);
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got 0x%0h expected <empty queue>", tag, got);
      end else begin
         check(tag, 32'(got), 32'(exp_q.pop_front()));
      end
   endtask

   // ---------------- behavioural slave ----------------
   logic       ack_addr = 1'b1, ack_data = 1'b1;
   logic [7:0] slv_rd_byte = '0;
   logic       in_xfer = 1'b0, xfer_rw = 1'b0;
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   logic [7:0] addr_cap = '0, data_cap = '0;
   int         fall_cnt = 0, rise_cnt = 0, stop_cnt = 0, rd_oe_viol = 0;

   // Track SCL/SDA edges on the falling clk edge; drive ACKs and read bits.
   always @(negedge clk) begin
      logic cur_sda;
      cur_sda = ~(sda_oe | slave_low);
      if (!reset) begin
         in_xfer   = 1'b0;
         fall_cnt  = 0;
         rise_cnt  = 0;
         slave_low = 1'b0;
         prev_scl  = 1'b1;
         prev_sda  = 1'b1;
      end else begin
         if (prev_scl && scl && prev_sda && !cur_sda) begin
            in_xfer  = 1'b1;
            xfer_rw  = 1'b0;
            fall_cnt = 0;
            rise_cnt = 0;
         end else if (in_xfer && prev_scl && !scl) begin
            fall_cnt++;
            slave_low = 1'b0;
            if (fall_cnt == 9) slave_low = ack_addr;
            else if (xfer_rw && fall_cnt >= 10 && fall_cnt <= 17) slave_low = ~slv_rd_byte[17 - fall_cnt];
            else if (!xfer_rw && fall_cnt == 18) slave_low = ack_data;
         end else if (in_xfer && !prev_scl && scl) begin
            rise_cnt++;
            if (rise_cnt <= 8) addr_cap = {addr_cap[6:0], cur_sda};
            else if (rise_cnt >= 10 && rise_cnt <= 17) data_cap = {data_cap[6:0], cur_sda};
            if (rise_cnt == 8) xfer_rw = cur_sda;
         end else if (in_xfer && prev_scl && scl && !prev_sda && cur_sda) begin
            in_xfer = 1'b0;
            stop_cnt++;
         end
         if (in_xfer && xfer_rw && fall_cnt >= 10 && fall_cnt <= 18 && sda_oe) rd_oe_viol++;
         prev_scl = scl;
         prev_sda = ~(sda_oe | slave_low);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!done && cyc < 2000);
      check("done_seen", 32'(done), 32'd1);
   endtask

   task automatic run_xact(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                           input logic aa, input logic ad, input logic [7:0] rb);
      int cyc;
      int stops0;
      logic exp_err;
      exp_err     = !aa || (!rw && !ad);
      ack_addr    = aa;
      ack_data    = ad;
      slv_rd_byte = rb;
      exp_q.push_back({a, rw});
      if (aa) exp_q.push_back(rw ? rb : wd);
      check("ready_before_cmd", 32'(cmd_ready), 32'd1);
      stops0    = stop_cnt;
      cmd_addr  = a;
      cmd_rw    = rw;
      cmd_wdata = wd;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
      wait_done(cyc);
      check("done_latency", 32'(cyc), aa ? 32'(FULL_CYC) : 32'(NACK_CYC));
      check("ack_err", 32'(ack_err), 32'(exp_err));
      check("rd_data", 32'(rd_data), rw ? 32'(rb) : 32'd0);
      check("ready_at_done", 32'(cmd_ready), 32'd1);
      check("busy_at_done", 32'(busy), 32'd0);
      check("scl_rises", 32'(rise_cnt), aa ? 32'd19 : 32'd10);
      check("stop_seen", 32'(stop_cnt - stops0), 32'd1);
      check_byte("addr_byte", addr_cap);
      if (aa) check_byte("data_byte", data_cap);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;

      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_scl", 32'(scl), 32'd1);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ack_err", 32'(ack_err), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Write with ACKs, address NACK, read, data NACK.
      run_xact(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
      run_xact(7'h3F, 1'b0, 8'h77, 1'b0, 1'b1, 8'h00);
      run_xact(7'h21, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h3C);
      check("rd_sda_released", 32'(rd_oe_viol), 32'd0);
      run_xact(7'h2A, 1'b0, 8'h96, 1'b1, 1'b0, 8'h00);

      // Back-to-back: cmd_valid held high, fields change while busy.
      ack_addr  = 1'b1;
      ack_data  = 1'b1;
      cmd_addr  = 7'h12;
      cmd_rw    = 1'b0;
      cmd_wdata = 8'h5A;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_addr  = 7'h6B;
      cmd_wdata = 8'hC3;
      wait_done(cyc);
      check("b2b_first_latency", 32'(cyc), 32'(FULL_CYC));
      check("b2b_ready_at_done", 32'(cmd_ready), 32'd1);
      check("b2b_first_addr", 32'(addr_cap), 32'h24);
      check("b2b_first_data", 32'(data_cap), 32'h5A);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("b2b_second_busy", 32'(busy), 32'd1);
      check("b2b_second_ready", 32'(cmd_ready), 32'd0);
      check("b2b_start_scl", 32'(scl), 32'd1);
      check("b2b_start_sda_oe", 32'(sda_oe), 32'd0);
      check("b2b_start_state", 32'(dbg_state), 32'(ST_START));
      wait_done(cyc);
      check("b2b_second_latency", 32'(cyc), 32'(FULL_CYC));
      check("b2b_second_addr", 32'(addr_cap), 32'hD6);
      check("b2b_second_data", 32'(data_cap), 32'hC3);

      // Reset in the middle of the write data byte.
      ack_addr  = 1'b1;
      cmd_addr  = 7'h50;
      cmd_rw    = 1'b0;
      cmd_wdata = 8'h0F;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (13 * 4 * CLK_DIV) @(posedge clk);
      #1;
      check("mid_state_wdata", 32'(dbg_state), 32'(ST_WDATA));
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_scl", 32'(scl), 32'd1);
      check("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_done", 32'(done), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      run_xact(7'h50, 1'b0, 8'h0F, 1'b1, 1'b1, 8'h00);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
